// File: rtl/ttl_374_bus_sequencer_if.sv
// rtl/ttl_374_bus_sequencer_if.sv - shared-bus request/grant/enable bundle for four octal D registers
`timescale 1ns/1ps
interface ttl_374_bus_sequencer_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] load;
  logic [3:0] oc_bar;
  logic [1:0] owner;
  logic       busy;

  modport master (input req, output grant, load, oc_bar, owner, busy);
  modport slave  (output req, input grant, load, oc_bar, owner, busy);
endinterface

// File: rtl/ttl_374_bus_sequencer.sv
// rtl/ttl_374_bus_sequencer.sv - round-robin capture/drive/turnaround sequencer for four tri-state octal registers
`timescale 1ns/1ps
module ttl_374_bus_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned DELAY_RISE  = 0,
  parameter int unsigned DELAY_FALL  = 0
) (
  input  logic                           clk,
  input  logic                           clear_bar,
  ttl_374_bus_sequencer_if.master        bus
);

  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

  // Propagation delays are a board-level annotation only; the logic is zero-delay.
  if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_delay_annotation
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRIVE = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] owner_q;
  logic [3:0] cnt;
  logic [1:0] sel;
  logic [1:0] idx;
  logic       any_req;

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  // Walk offsets 4..1 so the nearest requester after the last owner is assigned last and wins;
  // offset 4 is the last owner itself, which therefore has lowest priority.
  always_comb begin
    sel     = owner_q;
    idx     = owner_q;
    any_req = |bus.req;
    for (int i = 4; i >= 1; i--) begin
      idx = owner_q + 2'(i);
      if (bus.req[idx]) sel = idx;
    end
  end

  assign bus.owner = owner_q;

  always_ff @(posedge clk or negedge clear_bar) begin
    if (!clear_bar) begin
      state      <= IDLE;
      owner_q    <= 2'd3;
      cnt        <= 4'd0;
      bus.grant  <= 4'b0000;
      bus.load   <= 4'b0000;
      bus.oc_bar <= 4'b1111;
      bus.busy   <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            state      <= LOAD;
            owner_q    <= sel;
            bus.load   <= onehot(sel);
            bus.grant  <= onehot(sel);
            bus.oc_bar <= 4'b1111;
            bus.busy   <= 1'b1;
          end else begin
            state      <= IDLE;
            bus.load   <= 4'b0000;
            bus.grant  <= 4'b0000;
            bus.oc_bar <= 4'b1111;
            bus.busy   <= 1'b0;
          end
        end
        LOAD: begin
          state      <= DRIVE;
          cnt        <= HOLD;
          bus.load   <= 4'b0000;
          bus.grant  <= onehot(owner_q);
          bus.oc_bar <= ~onehot(owner_q);
          bus.busy   <= 1'b1;
        end
        DRIVE: begin
          // Req is ignored here: once loaded, a transaction always runs its full hold time.
          if (cnt <= 4'd1) begin
            state      <= GAP;
            cnt        <= 4'd0;
            bus.grant  <= 4'b0000;
            bus.oc_bar <= 4'b1111;
          end else begin
            cnt <= cnt - 4'd1;
          end
          bus.load <= 4'b0000;
          bus.busy <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          cnt        <= 4'd0;
          bus.grant  <= 4'b0000;
          bus.load   <= 4'b0000;
          bus.oc_bar <= 4'b1111;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttl_374_bus_sequencer.sv
// tb/tb_ttl_374_bus_sequencer.sv - scoreboard bench for ttl_374_bus_sequencer
`timescale 1ns/1ps
module tb_ttl_374_bus_sequencer;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic clear_bar = 1'b0;
  always #5 clk = ~clk;

  ttl_374_bus_sequencer_if bus2 ();
  ttl_374_bus_sequencer_if bus15 ();

  ttl_374_bus_sequencer #(.HOLD_CYCLES(HOLD), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .clk(clk), .clear_bar(clear_bar), .bus(bus2.master));
  ttl_374_bus_sequencer #(.HOLD_CYCLES(15), .DELAY_RISE(0), .DELAY_FALL(0)) dut15 (
    .clk(clk), .clear_bar(clear_bar), .bus(bus15.master));

  typedef struct { int owner; bit b2b; } txn_t;
  typedef struct { int drive; int busy; } long_t;
  txn_t  q[$];
  long_t q15[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the HOLD=2 instance: pops one expected transaction per Load pulse.
  int   since = 1000;
  bit   tracking = 0;
  int   drive_cnt = 0;
  int   cur = 0;
  logic [3:0] oc_exp;
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (!clear_bar) begin
        tracking = 0;
        since = 1000;
      end else begin
        check("oc_overlap", 32'($countones(~bus2.oc_bar) <= 1), 32'd1);
        since++;
        if (bus2.load != 4'b0000) begin
          if (q.size() == 0) begin
            check("unexpected_load", 32'(bus2.load), 32'd0);
          end else begin
            e = q.pop_front();
            check("load_onehot", 32'(bus2.load), 32'(4'b0001 << e.owner));
            check("owner", 32'(bus2.owner), 32'(e.owner));
            check("load_oc_bar", 32'(bus2.oc_bar), 32'hF);
            check("load_grant", 32'(bus2.grant), 32'(bus2.load));
            if (e.b2b) check("regrant_interval", 32'(since), 32'(HOLD + 2));
            cur = e.owner;
          end
          since = 0;
          tracking = 1;
          drive_cnt = 0;
        end else if (tracking) begin
          oc_exp = ~(4'b0001 << cur);
          if (bus2.oc_bar == oc_exp && bus2.grant == (4'b0001 << cur)) begin
            drive_cnt++;
          end else begin
            check("drive_cycles", 32'(drive_cnt), 32'(HOLD));
            check("gap_oc_bar", 32'(bus2.oc_bar), 32'hF);
            check("gap_grant", 32'(bus2.grant), 32'd0);
            check("gap_busy", 32'(bus2.busy), 32'd1);
            tracking = 0;
          end
        end
      end
    end
  end

  // Monitor for the HOLD=15 instance: measures drive and busy run lengths.
  int dc15 = 0;
  int bc15 = 0;
  initial begin
    long_t e;
    forever begin
      @(negedge clk);
      if (!clear_bar) begin
        dc15 = 0;
        bc15 = 0;
      end else begin
        if (bus15.oc_bar == 4'b1110) dc15++;
        if (bus15.busy) begin
          bc15++;
        end else if (bc15 > 0) begin
          if (q15.size() == 0) begin
            check("unexpected_busy15", 32'(bc15), 32'd0);
          end else begin
            e = q15.pop_front();
            check("drive15_cycles", 32'(dc15), 32'(e.drive));
            check("busy15_cycles", 32'(bc15), 32'(e.busy));
          end
          dc15 = 0;
          bc15 = 0;
        end
      end
    end
  end

  task automatic wait_q_empty(input int max, input string name);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (bus2.busy && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(bus2.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_bar = 1'b0;
    @(posedge clk); #1;
    clear_bar = 1'b1;
  endtask

  initial begin
    bus2.req  = 4'b0000;
    bus15.req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(bus2.grant), 32'd0);
    check("rst_load", 32'(bus2.load), 32'd0);
    check("rst_oc_bar", 32'(bus2.oc_bar), 32'hF);
    check("rst_busy", 32'(bus2.busy), 32'd0);
    check("rst_owner", 32'(bus2.owner), 32'd3);
    clear_bar = 1'b1;

    // Two requesters: 0 first out of reset, then 2 straight from the turnaround.
    q.push_back('{0, 1'b0});
    q.push_back('{2, 1'b1});
    bus2.req = 4'b0101;
    wait_q_empty(30, "t0101_timeout");
    bus2.req = 4'b0000;
    wait_idle(20, "t0101_idle");

    // All four requesting: full rotation 0,1,2,3,0 at 4-cycle spacing.
    do_reset();
    q.push_back('{0, 1'b0});
    for (int i = 1; i <= 4; i++) q.push_back('{i % 4, 1'b1});
    bus2.req = 4'b1111;
    wait_q_empty(40, "t1111_timeout");
    bus2.req = 4'b0000;
    wait_idle(20, "t1111_idle");

    // Sole requester 3 held: re-granted every HOLD+2 cycles.
    q.push_back('{3, 1'b0});
    q.push_back('{3, 1'b1});
    q.push_back('{3, 1'b1});
    bus2.req = 4'b1000;
    wait_q_empty(30, "t1000_timeout");
    bus2.req = 4'b0000;
    wait_idle(20, "t1000_idle");

    // One-cycle pulse on Req[1] still yields a complete transaction.
    q.push_back('{1, 1'b0});
    bus2.req = 4'b0010;
    @(posedge clk); #1;
    bus2.req = 4'b0000;
    wait_q_empty(10, "tpulse_timeout");
    wait_idle(20, "tpulse_idle");

    // Asynchronous reset in the middle of owner 2's drive window.
    q.push_back('{2, 1'b0});
    bus2.req = 4'b0100;
    wait_q_empty(10, "tmid_timeout");
    bus2.req = 4'b0000;
    check("mid_drive_oc_bar", 32'(bus2.oc_bar), 32'hB);
    #2;
    clear_bar = 1'b0;
    #1;
    check("async_oc_bar", 32'(bus2.oc_bar), 32'hF);
    check("async_grant", 32'(bus2.grant), 32'd0);
    check("async_busy", 32'(bus2.busy), 32'd0);
    check("async_owner", 32'(bus2.owner), 32'd3);
    @(posedge clk); #1;
    clear_bar = 1'b1;
    q.push_back('{2, 1'b0});
    bus2.req = 4'b0100;
    @(posedge clk); #1;
    bus2.req = 4'b0000;
    wait_q_empty(10, "tpost_timeout");
    wait_idle(20, "tpost_idle");

    // Long hold: 15 drive cycles, 17 busy cycles.
    q15.push_back('{15, 17});
    bus15.req = 4'b0001;
    @(posedge clk); #1;
    bus15.req = 4'b0000;
    begin
      int n = 0;
      while (q15.size() != 0 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("t15_timeout", 32'(q15.size()), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("final_queue", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
